gcd_frac_reduce: RTL

Downstream consumer of the gcd unit. Takes an operand pair (a, b) together with its gcd, divides both operands by the gcd, and emits the reduced fraction a/g : b/g. Division uses a shared-divisor iterative restoring divider, one quotient bit of each operand per cycle. It sits between the gcd result handshake (valid/yumi) and the next pipeline consumer (valid/yumi).

---
 rtl/gcd_frac_reduce_if.sv | 26 ++
 rtl/gcd_frac_reduce.sv | 139 +++++++++++++
 2 files changed

// File: rtl/gcd_frac_reduce_if.sv
// Handshake bundle between the gcd stage, the fraction reducer and its downstream consumer.
// The slave modport is the reducer's view; the master modport is the producer/consumer view.
interface gcd_frac_reduce_if #(
    parameter int width_p = 32
);
    logic [width_p-1:0] a_i;
    logic [width_p-1:0] b_i;
    logic [width_p-1:0] gcd_i;
    logic               v_i;
    logic               yumi_o;
    logic [width_p-1:0] num_o;
    logic [width_p-1:0] den_o;
    logic               err_o;
    logic               v_o;
    logic               yumi_i;

    modport slave (
        input  a_i, b_i, gcd_i, v_i, yumi_i,
        output yumi_o, num_o, den_o, err_o, v_o
    );

    modport master (
        output a_i, b_i, gcd_i, v_i, yumi_i,
        input  yumi_o, num_o, den_o, err_o, v_o
    );
endinterface

// File: rtl/gcd_frac_reduce.sv
// Reduces a/b by their gcd using a shared-divisor restoring divider, one quotient bit per operand per cycle.
// Define GCD_REDUCE_CHECK_EN to flag a nonzero final remainder on err_o.
module gcd_frac_reduce #(
    parameter int width_p = 32
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    gcd_frac_reduce_if.slave    bus
);
    localparam int cnt_w_lp = (width_p > 2) ? $clog2(width_p) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              r_state;
    logic [cnt_w_lp-1:0] r_cnt;
    logic [width_p-1:0]  r_dvd_a;
    logic [width_p-1:0]  r_dvd_b;
    logic [width_p-1:0]  r_dsr;
    logic [width_p:0]    r_rem_a;
    logic [width_p:0]    r_rem_b;
    logic [width_p-1:0]  r_quo_a;
    logic [width_p-1:0]  r_quo_b;
    logic [width_p-1:0]  r_num;
    logic [width_p-1:0]  r_den;
    logic                r_err;
    logic                r_v;

    logic [width_p:0]    w_dsr_ext;
    logic [width_p:0]    w_shift_a;
    logic [width_p:0]    w_shift_b;
    logic                w_q_a;
    logic                w_q_b;
    logic [width_p:0]    w_rem_nxt_a;
    logic [width_p:0]    w_rem_nxt_b;
    logic [width_p-1:0]  w_quo_nxt_a;
    logic [width_p-1:0]  w_quo_nxt_b;
    logic                w_rem_bad;

    // Restoring step: bring in the next dividend bit, subtract the divisor when it fits.
    assign w_dsr_ext   = {1'b0, r_dsr};
    assign w_shift_a   = (r_rem_a << 1) | {{width_p{1'b0}}, r_dvd_a[width_p-1]};
    assign w_shift_b   = (r_rem_b << 1) | {{width_p{1'b0}}, r_dvd_b[width_p-1]};
    assign w_q_a       = (w_shift_a >= w_dsr_ext);
    assign w_q_b       = (w_shift_b >= w_dsr_ext);
    assign w_rem_nxt_a = w_q_a ? (w_shift_a - w_dsr_ext) : w_shift_a;
    assign w_rem_nxt_b = w_q_b ? (w_shift_b - w_dsr_ext) : w_shift_b;
    assign w_quo_nxt_a = (r_quo_a << 1) | {{(width_p-1){1'b0}}, w_q_a};
    assign w_quo_nxt_b = (r_quo_b << 1) | {{(width_p-1){1'b0}}, w_q_b};

`ifdef GCD_REDUCE_CHECK_EN
    assign w_rem_bad = (w_rem_nxt_a != '0) || (w_rem_nxt_b != '0);
`else
    assign w_rem_bad = 1'b0;
`endif

    // Accept only from IDLE, and never while reset is held, so the gcd stage cannot lose a bundle.
    assign bus.yumi_o = reset_n_i && (r_state == IDLE) && bus.v_i;
    assign bus.num_o  = r_num;
    assign bus.den_o  = r_den;
    assign bus.err_o  = r_err;
    assign bus.v_o    = r_v;

    // NOTE: every register here is updated with <= so all of them see pre-edge values in the same cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dvd_a <= '0;
            r_dvd_b <= '0;
            r_dsr   <= '0;
            r_rem_a <= '0;
            r_rem_b <= '0;
            r_quo_a <= '0;
            r_quo_b <= '0;
            r_num   <= '0;
            r_den   <= '0;
            r_err   <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.v_i) begin
                        r_dvd_a <= bus.a_i;
                        r_dvd_b <= bus.b_i;
                        r_dsr   <= bus.gcd_i;
                        r_rem_a <= '0;
                        r_rem_b <= '0;
                        r_quo_a <= '0;
                        r_quo_b <= '0;
                        r_cnt   <= cnt_w_lp'(width_p - 1);
                        if (bus.gcd_i == '0) begin
                            r_state <= DONE;
                            r_num   <= '0;
                            r_den   <= '0;
                            r_err   <= 1'b1;
                            r_v     <= 1'b1;
                        end else begin
                            r_state <= DIV;
                        end
                    end
                end

                DIV: begin
                    r_dvd_a <= r_dvd_a << 1;
                    r_dvd_b <= r_dvd_b << 1;
                    r_rem_a <= w_rem_nxt_a;
                    r_rem_b <= w_rem_nxt_b;
                    r_quo_a <= w_quo_nxt_a;
                    r_quo_b <= w_quo_nxt_b;
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        r_num   <= w_quo_nxt_a;
                        r_den   <= w_quo_nxt_b;
                        r_err   <= w_rem_bad;
                        r_v     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - cnt_w_lp'(1);
                    end
                end

                DONE: begin
                    if (bus.yumi_i) begin
                        r_state <= IDLE;
                        r_v     <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_v     <= 1'b0;
                end
            endcase
        end
    end
endmodule
